serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 72 +++++++
 tb/tb_serial_subtractor.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b over WIDTH cycles, IDLE/RUN/DONE FSM.
// Define SERIAL_SUB_ZERO_FLAG_EN to add a registered zero output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,output logic            zero
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
    logic [CW-1:0] cnt;
    logic br, d, br_next, last, accept;
    always_comb begin
        d = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_next = {d, res[WIDTH-1:1]};
        last = cnt == CW'(WIDTH - 1);
        accept = start && state != RUN;
        state_next = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_next;
    // results land only on the final RUN cycle, so diff holds the old value during RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            res <= '0;
            br <= 1'b0;
            cnt <= '0;
            diff <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero <= 1'b0;
`endif
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            res <= '0;
            br <= 1'b0;
            cnt <= '0;
        end else if (busy) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res <= res_next;
            br <= br_next;
            cnt <= cnt + 1'b1;
            if (last) begin
                diff <= res_next;
                borrow_out <= br_next;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                zero <= res_next == '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of serial_subtractor against arithmetic a - b.
module tb_serial_subtractor;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst, start;
    logic [W-1:0] a, b, diff;
    logic borrow_out, busy, done;
    logic [W-1:0] prev_diff;
    logic prev_br, prev_zero;
    int n_vec = 0;
    int n_err = 0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic zero;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .diff(diff), .borrow_out(borrow_out), .busy(busy), .done(done)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        ,.zero(zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [W-1:0] ed, input logic eb, input logic ez,
                            input logic eby, input logic edn);
        chk({tag, " diff"}, 32'(diff), 32'(ed));
        chk({tag, " borrow"}, 32'(borrow_out), 32'(eb));
        chk({tag, " busy"}, 32'(busy), 32'(eby));
        chk({tag, " done"}, 32'(done), 32'(edn));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        chk({tag, " zero"}, 32'(zero), 32'(ez));
`endif
    endtask

    // called at a negedge; returns at the negedge of the DONE cycle (or after an abort)
    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input int abort_at);
        logic [W-1:0] ed;
        logic eb;
        ed = W'(x - y);
        eb = x < y;
        start = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                #2 rst = 1'b1;
                #1 chk_outs("abort", '0, 1'b0, 1'b0, 1'b0, 1'b0);
                prev_diff = '0;
                prev_br = 1'b0;
                prev_zero = 1'b0;
                start = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk_outs("in_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
                rst = 1'b0;
                return;
            end
            if (i <= W) begin
                chk_outs("run", prev_diff, prev_br, prev_zero, 1'b1, 1'b0);
                start = i == 2 ? 1'b1 : 1'($urandom_range(0, 1));
                a = i == 2 ? 8'h00 : W'($urandom);
                b = i == 2 ? 8'hFF : W'($urandom);
            end else begin
                chk_outs("done", ed, eb, ed == '0, 1'b0, 1'b1);
                prev_diff = ed;
                prev_br = eb;
                prev_zero = ed == '0;
            end
        end
    endtask

    task automatic idle();
        start = 1'b0;
        @(negedge clk);
        chk_outs("idle", prev_diff, prev_br, prev_zero, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        prev_diff = '0;
        prev_br = 1'b0;
        prev_zero = 1'b0;
        #1 chk_outs("reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_outs("reset_hold", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        op(8'h05, 8'h03, 0);
        idle();
        op(8'h03, 8'h05, 0);
        idle();
        op(8'hFF, 8'h01, 0);
        idle();
        op(8'h00, 8'h00, 0);
        idle();
        op(8'h10, 8'h01, 0);
        idle();
        idle();
        op(8'h55, 8'hAA, 4);
        op(8'h80, 8'h7F, 0);
        op(8'h12, 8'h34, 0);
        op(8'h34, 8'h12, 0);
        op(8'hFF, 8'hFF, 0);
        idle();
        for (int k = 0; k < 30; k++) begin
            op(W'($urandom), W'($urandom), 0);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
